// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, FIFO entry layout
// and the instruction width in bytes.
package ifetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } fetch_entry_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage signal bundle: ROM address/data port, branch redirect and the
// valid/ready instruction handoff to decode.
interface ifetch_if;

  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  modport master (
    output HADDR, HWDATA, inst_valid, inst, inst_pc, inst_fault,
    input  HRDATA, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  HADDR, HWDATA, inst_valid, inst, inst_pc, inst_fault,
    output HRDATA, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous instruction FIFO with flush; the head entry is presented
// straight from the storage registers so decode sees registered outputs.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as all-zero until first fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC and RUN/HALT state, checks the
// ROM window, and feeds fetched words (or a fault marker) into the FIFO.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] ROM_START  = 64'h0,
  parameter int unsigned ROM_SIZE   = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic      HCLK,
  input logic      HRESETn,
  ifetch_if.master bus
);

  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [63:0] LEGAL_SPAN = 64'(ROM_SIZE) - 64'd8;

  fetch_state_e  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          pc_legal;
  logic          slot_avail;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [CW-1:0] count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          unused_bits;

  assign unused_bits = ^{bus.HRDATA[63:32], bus.redirect_pc[1:0]};

  // Unsigned offset wraps huge when pc < ROM_START, so one compare covers both bounds.
  assign pc_legal   = (pc_q - ROM_START) < LEGAL_SPAN;
  assign pop        = head_valid && bus.inst_ready;
  assign slot_avail = (count < CW'(FIFO_DEPTH)) || pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    push_entry = '0;
    if (bus.redirect_valid) begin
      state_d = RUN;
      pc_d    = {bus.redirect_pc[63:2], 2'b00};
    end else if (state_q == RUN && slot_avail) begin
      push          = 1'b1;
      push_entry.pc = pc_q;
      if (pc_legal) begin
        push_entry.inst = bus.HRDATA[31:0];
        pc_d            = pc_q + 64'(INST_BYTES);
      end else begin
        push_entry.fault = 1'b1;
        state_d          = HALT;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (head_valid),
    .count_o     (count)
  );

  assign bus.HADDR      = pc_q;
  assign bus.HWDATA     = '0;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_fault = head.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random ready/redirect traffic,
// checked every cycle against a queue-based model of the fetch buffer.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam logic [63:0] RESET_PC   = 64'h0;
  localparam logic [63:0] ROM_START  = 64'h0;
  localparam int unsigned ROM_SIZE   = 256;
  localparam int unsigned FIFO_DEPTH = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ifetch_if bus ();

  ifetch_unit #(
    .RESET_PC   (RESET_PC),
    .ROM_START  (ROM_START),
    .ROM_SIZE   (ROM_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom_b [512];

  always_comb begin
    bus.HRDATA = '0;
    for (int k = 0; k < 8; k++)
      bus.HRDATA[8*k +: 8] = rom_b[9'(bus.HADDR[8:0] + 9'(k))];
  end

  // Model: expected FIFO contents, fetch PC and halted flag.
  fetch_entry_t q[$];
  logic [63:0]  m_pc;
  bit           m_halt;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    logic [8:0] b;
    b = a[8:0];
    return {rom_b[b + 9'd3], rom_b[b + 9'd2], rom_b[b + 9'd1], rom_b[b]};
  endfunction

  function automatic bit legal(input logic [63:0] a);
    return (a >= ROM_START) && (a < ROM_START + 64'(ROM_SIZE) - 64'd8);
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) rom_b[a + k] = w[8*k +: 8];
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("inst_valid", 64'(bus.inst_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("inst", 64'(bus.inst), 64'(q[0].inst));
      check("inst_pc", bus.inst_pc, q[0].pc);
      check("inst_fault", 64'(bus.inst_fault), 64'(q[0].fault));
    end
    check("HADDR", bus.HADDR, m_pc);
    check("HWDATA", bus.HWDATA, 64'h0);
  endtask

  // Called one time unit after a rising edge: drive inputs, check, advance model.
  task automatic cycle(input bit rv, input logic [63:0] rpc, input bit rdy);
    bit pop;
    bit slot;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = rdy;
    compare_outputs();
    if (rv) begin
      q.delete();
      m_pc   = {rpc[63:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      pop  = (q.size() != 0) && rdy;
      slot = (q.size() < FIFO_DEPTH) || pop;
      if (pop) void'(q.pop_front());
      if (!m_halt && slot) begin
        if (legal(m_pc)) begin
          q.push_back(fetch_entry_t'{inst: rom_word(m_pc), pc: m_pc, fault: 1'b0});
          m_pc = m_pc + 64'd4;
        end else begin
          q.push_back(fetch_entry_t'{inst: 32'h0, pc: m_pc, fault: 1'b1});
          m_halt = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    #1;
    check("rst_inst_valid", 64'(bus.inst_valid), 64'h0);
    check("rst_HADDR", bus.HADDR, RESET_PC);
    check("rst_inst", 64'(bus.inst), 64'h0);
    check("rst_inst_pc", bus.inst_pc, 64'h0);
    check("rst_inst_fault", 64'(bus.inst_fault), 64'h0);
    check("rst_HWDATA", bus.HWDATA, 64'h0);
    q.delete();
    m_pc   = RESET_PC;
    m_halt = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit          rv;
    bit          rdy;
    logic [63:0] tgt;
    checks             = 0;
    errors             = 0;
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    for (int i = 0; i < 512; i++) rom_b[i] = 8'($urandom);
    put_word(0, 32'h04000093);
    put_word(4, 32'h00800113);
    put_word(8, 32'h00110133);
    put_word(12, 32'h00013183);
    put_word(20, 32'hfe000ce3);
    #2;

    // In-order stream from reset.
    apply_reset(3);
    repeat (6) cycle(1'b0, 64'h0, 1'b1);

    // Decode stalled after reset: buffer fills with 0,4 and HADDR parks at 8.
    apply_reset(2);
    repeat (5) cycle(1'b0, 64'h0, 1'b0);
    check("stall_HADDR", bus.HADDR, 64'h8);
    repeat (6) cycle(1'b0, 64'h0, 1'b1);

    // Redirect to misaligned 0x16 lands at 0x14 after one bubble.
    apply_reset(2);
    repeat (3) cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b1, 64'h16, 1'b1);
    check("redir_HADDR", bus.HADDR, 64'h14);
    repeat (4) cycle(1'b0, 64'h0, 1'b1);

    // Run off the end of the window, halt, then restart at 0.
    cycle(1'b1, 64'hF0, 1'b1);
    repeat (8) cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b1, 64'h0, 1'b1);
    repeat (3) cycle(1'b0, 64'h0, 1'b1);

    // Redirect while full and dequeuing: nothing from before survives.
    repeat (3) cycle(1'b0, 64'h0, 1'b0);
    cycle(1'b1, 64'h40, 1'b1);
    repeat (3) cycle(1'b0, 64'h0, 1'b1);

    // Asynchronous reset with a full buffer, then the reset stream again.
    repeat (3) cycle(1'b0, 64'h0, 1'b0);
    apply_reset(2);
    repeat (6) cycle(1'b0, 64'h0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       tgt = 64'($urandom_range(0, 255));
        1:       tgt = 64'($urandom_range(224, 280));
        2:       tgt = {$urandom, $urandom};
        default: tgt = 64'($urandom_range(0, 64));
      endcase
      cycle(rv, tgt, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly upstream of the instruction ROM and downstream-facing to decode. Holds the fetch PC, drives the ROM address bus, extracts the 32-bit instruction from the 64-bit read data, and buffers fetched instructions in a small FIFO. Decode consumes the FIFO through a valid/ready handshake. Branch redirects flush the FIFO and restart fetch.

## Interface
- RESET_PC, 64'h0: fetch PC loaded on reset.
- ROM_START, 64'h0: base of the fetchable window.
- ROM_SIZE, 256: window size in bytes. A fetch is legal iff ROM_START <= pc < ROM_START+ROM_SIZE-8.
- FIFO_DEPTH, 2: instruction buffer entries (power of two, >= 2).

- HCLK  in  1  clock.
- HRESETn  in  1  reset; one clock; reset is asynchronous and active-low.
- HADDR  out  64  ROM byte address = fetch_pc, driven combinationally.
- HWDATA  out  64  tied to 0.
- HRDATA  in  64  ROM read data; combinational, same cycle as HADDR; byte at HADDR in [7:0].
- redirect_valid  in  1  load new fetch PC this cycle.
- redirect_pc  in  64  target; bits [1:0] ignored (forced 0).
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst  out  32  head instruction.
- inst_pc  out  64  head PC.
- inst_fault  out  1  head is an access-fault marker (inst = 0).

## Operation
- States: RUN, HALT. Reset -> RUN, fetch_pc = RESET_PC, FIFO empty.
- RUN, no redirect: if pc legal and slot available, enqueue {HRDATA[31:0], fetch_pc, fault=0}, fetch_pc += 4. Slot available = count < FIFO_DEPTH, or count == FIFO_DEPTH and a dequeue occurs this edge.
- RUN, pc illegal, slot available: enqueue {0, fetch_pc, fault=1}, go HALT, fetch_pc unchanged.
- No slot available: hold fetch_pc, no enqueue.
- HALT: no enqueue; stay until redirect.
- Redirect (any state): flush FIFO (including entry being dequeued), fetch_pc = {redirect_pc[63:2],2'b00}, state RUN, no enqueue that edge. Redirect wins over simultaneous enqueue/dequeue.
- Dequeue when inst_valid && inst_ready.
- fetch_pc increment wraps modulo 2^64; wrapped address is treated by the legality check only.
- Outputs are the registered FIFO head; inst/inst_pc/inst_fault are don't-care when inst_valid = 0 but drive 0 after reset.

## Timing
- Reset values: HADDR = RESET_PC, HWDATA = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_fault = 0.
- Reset assertion mid-operation clears FIFO and state immediately (async); deassertion takes effect at next HCLK edge.
- First instruction: captured at the first rising edge after reset release; inst_valid high from that edge.
- Fetch-to-valid latency 1 cycle; sustained throughput 1 instruction/cycle with inst_ready held high.
- Redirect sampled at edge N: HADDR = target during cycle N+1, target instruction valid after edge N+1; inst_valid low during cycle N+1 (one-cycle bubble).
- Full FIFO, inst_ready low: HADDR stable, contents stable.

## Structure
- Shared package ifetch_pkg: fetch state enum (RUN, HALT), FIFO entry struct {inst[31:0], pc[63:0], fault}, INST_BYTES = 4.
- One sub-module: ifetch_fifo (synchronous FIFO, async active-low reset, flush input, count output). Remaining logic (PC, legality, FSM) in ifetch_unit.

## Test plan
- Reset, ROM preloaded with 0x04000093, 0x00800113, 0x00110133, 0x00013183 at 0,4,8,12, inst_ready = 1 -> instructions out in order with inst_pc 0,4,8,12 on consecutive cycles.
- inst_ready = 0 for 5 cycles after reset -> FIFO fills with PCs 0 and 4, HADDR holds 8; release -> 0,4,8 stream with no gap or duplicate.
- redirect_pc = 0x16 at cycle 3 -> FIFO flushed, HADDR = 0x14 next cycle, next valid inst = 0xfe000ce3 with inst_pc 0x14, one bubble cycle.
- redirect_pc = 0xF0, ROM_SIZE 256 -> PCs 0xF0, 0xF4 fetched, then fault entry inst_pc 0xF8, inst_fault = 1, inst_valid then stays 0 (HALT) until redirect to 0 restarts at PC 0.
- Redirect coincident with dequeue while full -> no entry survives; only redirect target appears next.
- HRESETn asserted mid-stream with FIFO full -> inst_valid drops immediately, HADDR = RESET_PC; restart matches first scenario.
